// File: rtl/rv_pkg.sv
// Shared core constants for the RV pipeline: datapath width, register count,
// instruction width and reset vector.
package rv_pkg;

   localparam int unsigned RV_XLEN     = 32;
   localparam int unsigned RV_NREG     = 32;
   localparam int unsigned RV_ILEN     = 32;
   localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

   // Which register-file read port an operand comes from
   typedef enum logic [0:0] {
      RD_PORT_RS1 = 1'b0,
      RD_PORT_RS2 = 1'b1
   } rd_port_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file bus: writeback, read, issue requests and registered read results.
interface reg_file_sb_if #(
   parameter int XLEN = rv_pkg::RV_XLEN,
   parameter int NREG = rv_pkg::RV_NREG
);
   localparam int AW = $clog2(NREG);

   logic            i_fWE;
   logic [AW-1:0]   i_Rd;
   logic [XLEN-1:0] i_Data;
   logic            i_fRE;
   logic [AW-1:0]   i_Rs1;
   logic [AW-1:0]   i_Rs2;
   logic            i_fIssue;
   logic [AW-1:0]   i_IssueRd;
   logic [XLEN-1:0] o_Data0;
   logic [XLEN-1:0] o_Data1;
   logic            o_fBusy0;
   logic            o_fBusy1;
   logic            o_fHazard;

   modport master (
      output i_fWE, i_Rd, i_Data, i_fRE, i_Rs1, i_Rs2, i_fIssue, i_IssueRd,
      input  o_Data0, o_Data1, o_fBusy0, o_fBusy1, o_fHazard
   );

   modport slave (
      input  i_fWE, i_Rd, i_Data, i_fRE, i_Rs1, i_Rs2, i_fIssue, i_IssueRd,
      output o_Data0, o_Data1, o_fBusy0, o_fBusy1, o_fHazard
   );

endinterface

// File: rtl/reg_file_sb_score.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on
// writeback, with a post-update lookup for the two read ports.
module reg_file_sb_score
   import rv_pkg::*;
#(
   parameter  int NREG = RV_NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   input  logic          i_fClr,
   input  logic [AW-1:0] i_ClrReg,
   input  logic          i_fSet,
   input  logic [AW-1:0] i_SetReg,
   input  logic [AW-1:0] i_Rs1,
   input  logic [AW-1:0] i_Rs2,
   output logic          o_fBusy1Next,
   output logic          o_fBusy2Next
);

   logic [NREG-1:1] r_Busy;
   logic [NREG-1:0] w_BusyNext;

   // Next busy vector; issue is checked first so a same-cycle issue beats writeback
   always_comb begin
      w_BusyNext    = {NREG{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         if (i_fSet && (i_SetReg == AW'(i))) begin
            w_BusyNext[i] = 1'b1;
         end else if (i_fClr && (i_ClrReg == AW'(i))) begin
            w_BusyNext[i] = 1'b0;
         end else begin
            w_BusyNext[i] = r_Busy[i];
         end
      end
   end

   // Busy vector state; x0 has no storage and is never busy
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_Busy <= {(NREG-1){1'b0}};
      end else begin
         r_Busy <= w_BusyNext[NREG-1:1];
      end
   end

   assign o_fBusy1Next = w_BusyNext[i_Rs1];
   assign o_fBusy2Next = w_BusyNext[i_Rs2];

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with writeback bypass, registered read
// ports and a pending-write scoreboard for hazard detection.
module reg_file_sb
   import rv_pkg::*;
#(
   parameter int XLEN = RV_XLEN,
   parameter int NREG = RV_NREG
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   reg_file_sb_if.slave  rf
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] r_Regs [NREG];
   logic [XLEN-1:0] r_Data0;
   logic [XLEN-1:0] r_Data1;
   logic            r_fBusy0;
   logic            r_fBusy1;
   logic [XLEN-1:0] w_Rd0;
   logic [XLEN-1:0] w_Rd1;
   logic            w_fWr;
   logic            w_fBusy0Next;
   logic            w_fBusy1Next;

   assign w_fWr = rf.i_fWE && (rf.i_Rd != {AW{1'b0}});

   reg_file_sb_score #(
      .NREG (NREG)
   ) u_score (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_fClr       (rf.i_fWE),
      .i_ClrReg     (rf.i_Rd),
      .i_fSet       (rf.i_fIssue),
      .i_SetReg     (rf.i_IssueRd),
      .i_Rs1        (rf.i_Rs1),
      .i_Rs2        (rf.i_Rs2),
      .o_fBusy1Next (w_fBusy0Next),
      .o_fBusy2Next (w_fBusy1Next)
   );

   // Register storage; entry 0 is never written and stays at its reset value
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_Regs[i] <= {XLEN{1'b0}};
         end
      end else if (w_fWr) begin
         r_Regs[rf.i_Rd] <= rf.i_Data;
      end
   end

   // Read muxes: x0 reads zero, a same-cycle writeback is forwarded
   always_comb begin
      if (rf.i_Rs1 == {AW{1'b0}}) begin
         w_Rd0 = {XLEN{1'b0}};
      end else if (w_fWr && (rf.i_Rd == rf.i_Rs1)) begin
         w_Rd0 = rf.i_Data;
      end else begin
         w_Rd0 = r_Regs[rf.i_Rs1];
      end

      if (rf.i_Rs2 == {AW{1'b0}}) begin
         w_Rd1 = {XLEN{1'b0}};
      end else if (w_fWr && (rf.i_Rd == rf.i_Rs2)) begin
         w_Rd1 = rf.i_Data;
      end else begin
         w_Rd1 = r_Regs[rf.i_Rs2];
      end
   end

   // Registered read results; they hold while reads are disabled
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_Data0  <= {XLEN{1'b0}};
         r_Data1  <= {XLEN{1'b0}};
         r_fBusy0 <= 1'b0;
         r_fBusy1 <= 1'b0;
      end else if (rf.i_fRE) begin
         r_Data0  <= w_Rd0;
         r_Data1  <= w_Rd1;
         r_fBusy0 <= w_fBusy0Next;
         r_fBusy1 <= w_fBusy1Next;
      end
   end

   assign rf.o_Data0   = r_Data0;
   assign rf.o_Data1   = r_Data1;
   assign rf.o_fBusy0  = r_fBusy0;
   assign rf.o_fBusy1  = r_fBusy1;
   assign rf.o_fHazard = r_fBusy0 | r_fBusy1;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus randomized traffic compared
// against an array-based model of register contents and pending writes.
module tb_reg_file_sb;
   import rv_pkg::*;

   localparam int XL = 32;
   localparam int NR = 32;
   localparam int AW = $clog2(NR);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_file_sb_if #(.XLEN(XL), .NREG(NR)) bus ();

   reg_file_sb #(.XLEN(XL), .NREG(NR)) dut (
      .i_Clk (clk),
      .i_Rst (rst_n),
      .rf    (bus)
   );

   logic [XL-1:0] m_regs [NR];
   bit            m_busy [NR];
   logic [XL-1:0] m_d0, m_d1;
   bit            m_b0, m_b1;
   int            n_chk = 0;
   int            n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_d0 = '0; m_d1 = '0; m_b0 = 1'b0; m_b1 = 1'b0;
   endtask

   // Apply this edge's writeback and issue, then read the post-update state.
   task automatic model_edge();
      if (bus.i_fWE && bus.i_Rd != 0) begin
         m_regs[bus.i_Rd] = bus.i_Data;
         m_busy[bus.i_Rd] = 1'b0;
      end
      if (bus.i_fIssue && bus.i_IssueRd != 0) m_busy[bus.i_IssueRd] = 1'b1;
      if (bus.i_fRE) begin
         m_d0 = (bus.i_Rs1 == 0) ? '0 : m_regs[bus.i_Rs1];
         m_d1 = (bus.i_Rs2 == 0) ? '0 : m_regs[bus.i_Rs2];
         m_b0 = (bus.i_Rs1 == 0) ? 1'b0 : m_busy[bus.i_Rs1];
         m_b1 = (bus.i_Rs2 == 0) ? 1'b0 : m_busy[bus.i_Rs2];
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".d0"}, bus.o_Data0, m_d0);
      check_val({tag, ".d1"}, bus.o_Data1, m_d1);
      check_val({tag, ".b0"}, bus.o_fBusy0, m_b0);
      check_val({tag, ".b1"}, bus.o_fBusy1, m_b1);
      check_val({tag, ".hz"}, bus.o_fHazard, m_b0 | m_b1);
   endtask

   task automatic step(input string tag, input bit we, input int rd, input logic [XL-1:0] data,
                       input bit re, input int rs1, input int rs2, input bit iss, input int issrd);
      bus.i_fWE     = we;
      bus.i_Rd      = AW'(rd);
      bus.i_Data    = data;
      bus.i_fRE     = re;
      bus.i_Rs1     = AW'(rs1);
      bus.i_Rs2     = AW'(rs2);
      bus.i_fIssue  = iss;
      bus.i_IssueRd = AW'(issrd);
      @(posedge clk);
      #1;
      if (rst_n) model_edge();
      check_outputs(tag);
   endtask

   // Assert reset between edges, hold it across one edge with a write and an issue pending.
   task automatic mid_reset(input string tag);
      #2;
      bus.i_fWE = 1'b1; bus.i_Rd = AW'(4); bus.i_Data = 32'hFFFF_0000;
      bus.i_fIssue = 1'b1; bus.i_IssueRd = AW'(4); bus.i_fRE = 1'b1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs({tag, ".now"});
      @(posedge clk);
      #1;
      check_outputs({tag, ".held"});
      #2;
      rst_n = 1'b1;
   endtask

   function automatic int rnd_addr();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NR - 1));
      else return int'($urandom_range(0, 5));
   endfunction

   initial begin
      rst_n = 1'b0;
      bus.i_fWE = 1'b0; bus.i_Rd = '0; bus.i_Data = '0; bus.i_fRE = 1'b0;
      bus.i_Rs1 = '0; bus.i_Rs2 = '0; bus.i_fIssue = 1'b0; bus.i_IssueRd = '0;
      model_reset();
      #12;
      check_outputs("reset");
      #1;
      rst_n = 1'b1;

      step("w5", 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 0);
      step("r5", 1'b0, 0, 32'h0, 1'b1, 5, 0, 1'b0, 0);
      check_val("x5_value", bus.o_Data0, 32'hDEAD_BEEF);

      step("w0", 1'b1, 0, 32'h0000_1234, 1'b1, 0, 0, 1'b0, 0);
      check_val("x0_d0", bus.o_Data0, 32'h0);
      check_val("x0_d1", bus.o_Data1, 32'h0);
      step("iss0", 1'b0, 0, 32'h0, 1'b1, 0, 0, 1'b1, 0);
      check_val("x0_busy", {bus.o_fBusy0, bus.o_fBusy1}, 2'b00);

      step("byp7", 1'b1, 7, 32'hA5A5_A5A5, 1'b1, 7, 7, 1'b0, 0);
      check_val("byp7_d0", bus.o_Data0, 32'hA5A5_A5A5);
      check_val("byp7_d1", bus.o_Data1, 32'hA5A5_A5A5);

      step("iss3", 1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1, 3);
      step("rd3", 1'b0, 0, 32'h0, 1'b1, 3, 0, 1'b0, 0);
      check_val("x3_busy", bus.o_fBusy0, 1'b1);
      check_val("x3_hazard", bus.o_fHazard, 1'b1);
      step("wb3", 1'b1, 3, 32'h0000_0010, 1'b1, 3, 0, 1'b0, 0);
      check_val("x3_clear", bus.o_fBusy0, 1'b0);
      check_val("x3_data", bus.o_Data0, 32'h0000_0010);

      step("isswb9", 1'b1, 9, 32'h0000_0055, 1'b0, 0, 0, 1'b1, 9);
      step("rd9", 1'b0, 0, 32'h0, 1'b1, 9, 0, 1'b0, 0);
      check_val("x9_data", bus.o_Data0, 32'h0000_0055);
      check_val("x9_busy", bus.o_fBusy0, 1'b1);

      step("rd4a", 1'b0, 0, 32'h0, 1'b1, 4, 9, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         step("hold", 1'b1, 4, 32'h4400_0000 + 32'(i), 1'b0, 4, 9, 1'b0, 0);
         check_val("hold_d0", bus.o_Data0, 32'h0);
      end
      step("rd4b", 1'b0, 0, 32'h0, 1'b1, 4, 9, 1'b0, 0);
      check_val("x4_after_hold", bus.o_Data0, 32'h4400_0002);
      mid_reset("rst_a");
      check_val("rst_hazard", bus.o_fHazard, 1'b0);
      step("post_rst", 1'b0, 0, 32'h0, 1'b1, 4, 9, 1'b0, 0);
      check_val("post_rst_x4", bus.o_Data0, 32'h0);
      check_val("post_rst_b9", bus.o_fBusy1, 1'b0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) mid_reset("rst_r");
         else step("rnd", 1'($urandom), rnd_addr(), $urandom, ($urandom_range(0, 3) != 0),
                   rnd_addr(), rnd_addr(), 1'($urandom), rnd_addr());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
